// File: rtl/timekeeper_pkg.sv
// Shared types and constants for the timekeeper block.
//   tk_state_e      : control FSM states
//   *_W constants   : BCD field widths of the 20-bit time word
//   *_MAX constants : BCD field limits
//   bcd_time_valid  : range check applied to a time word before it is loaded
package timekeeper_pkg;

  localparam int unsigned UNITS_W    = 4;
  localparam int unsigned HR_TENS_W  = 2;
  localparam int unsigned MS_TENS_W  = 3;
  localparam int unsigned TIME_W     = 20;

  localparam int unsigned HOURS_MAX  = 23;
  localparam int unsigned MINSEC_MAX = 59;
  localparam int unsigned DIGIT_MAX  = 9;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_BUSY    = 2'd2
  } tk_state_e;

  // Layout: {hours tens, hours units, min tens, min units, sec tens, sec units}
  function automatic logic bcd_time_valid(input logic [TIME_W-1:0] t);
    logic [HR_TENS_W-1:0] h_t;
    logic [MS_TENS_W-1:0] m_t;
    logic [MS_TENS_W-1:0] s_t;
    logic [UNITS_W-1:0]   h_u;
    logic [UNITS_W-1:0]   m_u;
    logic [UNITS_W-1:0]   s_u;
    logic                 units_ok;
    logic                 hours_ok;
    logic                 ms_ok;
    {h_t, h_u, m_t, m_u, s_t, s_u} = t;
    units_ok = (h_u <= UNITS_W'(DIGIT_MAX)) && (m_u <= UNITS_W'(DIGIT_MAX)) &&
               (s_u <= UNITS_W'(DIGIT_MAX));
    // Units digits are already known to be <= 9, so only the top tens value
    // needs a units-digit limit.
    hours_ok = (h_t < HR_TENS_W'(HOURS_MAX / 10)) ||
               ((h_t == HR_TENS_W'(HOURS_MAX / 10)) && (h_u <= UNITS_W'(HOURS_MAX % 10)));
    ms_ok    = (m_t <= MS_TENS_W'(MINSEC_MAX / 10)) && (s_t <= MS_TENS_W'(MINSEC_MAX / 10));
    return units_ok && hours_ok && ms_ok;
  endfunction

endpackage

// File: rtl/timekeeper_bcd_mod_counter.sv
// Two-digit BCD counter with programmable modulus.
//   clk, rst_n : clock, synchronous active-low reset (clears to 00)
//   inc        : advance by one; wraps MOD-1 -> 00
//   load       : synchronous load of load_val (takes priority over inc)
//   load_val   : {tens, units} value to load
//   value      : {tens, units} current count
//   carry_out  : high in the cycle an increment wraps MOD-1 -> 00
module bcd_mod_counter
  import timekeeper_pkg::*;
#(
  parameter int unsigned MOD    = 60,
  parameter int unsigned TENS_W = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      inc,
  input  logic                      load,
  input  logic [TENS_W+UNITS_W-1:0] load_val,
  output logic [TENS_W+UNITS_W-1:0] value,
  output logic                      carry_out
);

  localparam logic [TENS_W-1:0]  TOP_TENS  = TENS_W'((MOD - 1) / 10);
  localparam logic [UNITS_W-1:0] TOP_UNITS = UNITS_W'((MOD - 1) % 10);

  logic [TENS_W-1:0]  tens_q,  tens_d;
  logic [UNITS_W-1:0] units_q, units_d;
  logic               at_top;

  always_comb begin
    at_top  = (tens_q == TOP_TENS) && (units_q == TOP_UNITS);
    tens_d  = tens_q;
    units_d = units_q;
    if (load) begin
      {tens_d, units_d} = load_val;
    end else if (inc) begin
      if (at_top) begin
        tens_d  = '0;
        units_d = '0;
      end else if (units_q == UNITS_W'(DIGIT_MAX)) begin
        tens_d  = tens_q + 1'b1;
        units_d = '0;
      end else begin
        units_d = units_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign value     = {tens_q, units_q};
  assign carry_out = inc && !load && at_top;

endmodule

// File: rtl/timekeeper.sv
// Time-of-day keeper (HH:MM:SS, BCD) with run/stop control and load port.
//   Clock, nReset : 32.768 kHz clock, synchronous active-low reset
//   tick_1Hz      : one-cycle seconds tick
//   Run           : 1 = count, 0 = hold
//   LoadValid/LoadReady/LoadTime : load handshake and BCD time to load
//   LoadError     : one-cycle pulse after an invalid load was accepted
//   Time          : current BCD time
//   Running       : high in RUNNING
//   DayWrap       : one-cycle pulse with the 23:59:59 -> 00:00:00 update
module timekeeper
  import timekeeper_pkg::*;
(
  input  logic              Clock,
  input  logic              nReset,
  input  logic              tick_1Hz,
  input  logic              Run,
  input  logic              LoadValid,
  output logic              LoadReady,
  input  logic [TIME_W-1:0] LoadTime,
  output logic              LoadError,
  output logic [TIME_W-1:0] Time,
  output logic              Running,
  output logic              DayWrap
);

  tk_state_e state_q, state_d;
  logic      load_error_q, load_error_d;
  logic      day_wrap_q, day_wrap_d;

  logic accept;
  logic load_ok;
  logic tick_adv;
  logic sec_carry, min_carry, hr_carry;
  logic [MS_TENS_W+UNITS_W-1:0] sec_val, min_val;
  logic [HR_TENS_W+UNITS_W-1:0] hr_val;

  assign accept   = LoadValid && LoadReady;
  assign load_ok  = accept && bcd_time_valid(LoadTime);
  // A load in the same cycle wins over the tick.
  assign tick_adv = tick_1Hz && (state_q == ST_RUNNING) && !accept;

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q      <= ST_STOPPED;
      load_error_q <= 1'b0;
      day_wrap_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_error_q <= load_error_d;
      day_wrap_q   <= day_wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = ST_BUSY;
    end else begin
      case (state_q)
        ST_STOPPED: if (Run)  state_d = ST_RUNNING;
        ST_RUNNING: if (!Run) state_d = ST_STOPPED;
        ST_BUSY:    state_d = Run ? ST_RUNNING : ST_STOPPED;
        default:    state_d = ST_STOPPED;
      endcase
    end
  end

  always_comb begin
    LoadReady    = (state_q != ST_BUSY);
    Running      = (state_q == ST_RUNNING);
    load_error_d = accept && !load_ok;
    day_wrap_d   = hr_carry;
  end

  assign LoadError = load_error_q;
  assign DayWrap   = day_wrap_q;

  bcd_mod_counter #(.MOD(60), .TENS_W(MS_TENS_W)) u_sec (
    .clk       (Clock),
    .rst_n     (nReset),
    .inc       (tick_adv),
    .load      (load_ok),
    .load_val  (LoadTime[6:0]),
    .value     (sec_val),
    .carry_out (sec_carry)
  );

  bcd_mod_counter #(.MOD(60), .TENS_W(MS_TENS_W)) u_min (
    .clk       (Clock),
    .rst_n     (nReset),
    .inc       (sec_carry),
    .load      (load_ok),
    .load_val  (LoadTime[13:7]),
    .value     (min_val),
    .carry_out (min_carry)
  );

  bcd_mod_counter #(.MOD(24), .TENS_W(HR_TENS_W)) u_hr (
    .clk       (Clock),
    .rst_n     (nReset),
    .inc       (min_carry),
    .load      (load_ok),
    .load_val  (LoadTime[19:14]),
    .value     (hr_val),
    .carry_out (hr_carry)
  );

  assign Time = {hr_val, min_val, sec_val};

endmodule

// File: doc/timekeeper.md
TIMEKEEPER -- requirements
Module: timekeeper

Interface
REQ-001 Clock  input  1  32.768 kHz system clock; all state updates on its rising edge.
REQ-002 nReset  input  1  reset, synchronous and active-low: sampled only on a rising Clock edge.
REQ-003 tick_1Hz  input  1  one-Clock-cycle pulse from the clock divider; 1 Hz normally, 64 Hz in Demo mode.
REQ-004 Run  input  1  level; 1 = count seconds, 0 = hold the current time.
REQ-005 LoadValid  input  1  load request; stays high until accepted.
REQ-006 LoadReady  output  1  block can accept a load in this cycle.
REQ-007 LoadTime  input  20  BCD time to load: [19:18] hours tens, [17:14] hours units, [13:11] minutes tens, [10:7] minutes units, [6:4] seconds tens, [3:0] seconds units.
REQ-008 LoadError  output  1  one-cycle pulse: an accepted load was rejected as invalid.
REQ-009 Time  output  20  current BCD time, same field layout as LoadTime.
REQ-010 Running  output  1  1 while in state RUNNING.
REQ-011 DayWrap  output  1  one-cycle pulse when the time rolls over from 23:59:59 to 00:00:00.

Function
REQ-012 FSM states: STOPPED, RUNNING, BUSY.
- STOPPED -> RUNNING when Run=1.
- RUNNING -> STOPPED when Run=0.
- Any state -> BUSY on load accept; BUSY lasts exactly 1 cycle, then goes to RUNNING if Run=1, otherwise STOPPED.
REQ-013 LoadReady SHALL be 1 in STOPPED and RUNNING and 0 in BUSY; a load is accepted when LoadValid and LoadReady are both 1 on a rising edge.
REQ-014 An accepted valid load SHALL appear on Time on the next cycle; load latency is 1 cycle.
REQ-015 A load is invalid when any of these hold: hours > 23, minutes > 59, seconds > 59, or any units digit > 9. An invalid load SHALL leave Time unchanged, still enter BUSY, and pulse LoadError in the cycle after acceptance.
REQ-016 In RUNNING, each tick_1Hz pulse SHALL advance Time by one second; Time SHALL update in the cycle after the tick.
REQ-017 Carry chain: seconds units 9->0 increments seconds tens; seconds 59->00 increments minutes; minutes 59->00 increments hours; hours units wrap 9->0 below 20, and 23->00 at the top.
REQ-018 On 23:59:59 + tick, Time SHALL become 00:00:00 and DayWrap SHALL pulse in that same update cycle.
REQ-019 Ticks in STOPPED or BUSY SHALL be ignored; they are not queued.
REQ-020 If a load accept and a tick occur in the same cycle, the load wins and the tick is dropped.
REQ-021 A change on Run SHALL take effect on the next edge; a tick in the same cycle as a Run 0->1 transition SHALL be ignored.
REQ-022 LoadError and DayWrap SHALL each be exactly 1 cycle wide and never asserted together.

Reset
REQ-023 With nReset=0 at a rising edge, the block SHALL go to: state STOPPED, Time=00:00:00, LoadReady=1, LoadError=0, DayWrap=0, Running=0.
REQ-024 Reset SHALL override everything, including a load or tick in progress; no partial update may survive it.

Structure
REQ-025 Shared package timekeeper_pkg SHALL hold the state enum, the BCD field-width constants, and the limit constants (23, 59, 9).
REQ-026 One sub-module, bcd_mod_counter, SHALL be used: a parameterised two-digit BCD counter with modulus, increment enable, synchronous load, and carry-out. It is instantiated three times, for seconds, minutes and hours.
REQ-027 Total RTL SHALL be 120-400 lines.

Verification
REQ-028 Reset, then Run=1 and 3 tick_1Hz pulses -> Time=00:00:03, Running=1.
REQ-029 Load 23:59:59, then 1 tick -> Time=00:00:00, DayWrap pulses for 1 cycle.
REQ-030 Load 12:60:00 -> LoadError pulses once, Time unchanged, LoadReady low for 1 cycle.
REQ-031 Load accepted in the same cycle as a tick while RUNNING from 10:00:00, loading 05:00:00 -> Time=05:00:00, no extra second counted.
REQ-032 Run=0 with 5 ticks from 09:59:59 -> Time stays 09:59:59; then Run=1 and 1 tick -> Time=10:00:00.
REQ-033 nReset asserted in the same cycle as LoadValid=1 carrying 11:11:11 -> Time=00:00:00, state STOPPED.
